// File: rtl/shift_frame_ctrl_pkg.sv
// shift_frame_ctrl_pkg
// Shared definitions for the serial-in/parallel-out frame controller:
// the FSM state encoding and the helper that sizes the bit counter.
// No ports. Optional build macro used by the design: SHIFT_FRAME_CTRL_PARITY_EN.
package shift_frame_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_HOLD  = ST_HOLD
  } state_e;

  // Bits needed to hold a count that runs 0..term inclusive.
  function automatic int cnt_width(input int term);
    return (term < 1) ? 1 : $clog2(term + 1);
  endfunction

endpackage

// File: rtl/shift_frame_ctrl_if.sv
// shift_frame_ctrl_if
// Bundles the bit-level input side (start, bit strobe, bit) and the
// word-level valid/ready output side of the frame controller.
//   slave  : controller view (consumes bits and ready, drives word/valid)
//   master : line receiver / consumer view (drives bits and ready)
// Parameter WIDTH: width of the parallel word.
interface shift_frame_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             start_i;
  logic             bit_valid_i;
  logic             bit_i;
  logic             word_valid_o;
  logic             word_ready_i;
  logic [WIDTH-1:0] word_o;

  modport slave (
    input  start_i, bit_valid_i, bit_i, word_ready_i,
    output word_valid_o, word_o
  );

  modport master (
    output start_i, bit_valid_i, bit_i, word_ready_i,
    input  word_valid_o, word_o
  );

endinterface

// File: rtl/shift_frame_ctrl_frame_bit_counter.sv
// frame_bit_counter
// Saturating beat counter for one frame.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : return count to 0 (wins over inc_i)
//   inc_i         : count one beat; holds once TERM is reached
//   cnt_o         : current count
//   tc_o          : high on the beat that brings the count to TERM
module frame_bit_counter
  import shift_frame_ctrl_pkg::*;
#(
  parameter int TERM  = 8,
  parameter int CNT_W = cnt_width(TERM)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TERM - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != TERM_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = inc_i && !clr_i && (cnt_q == LAST_C);

endmodule

// File: rtl/shift_frame_ctrl.sv
// shift_frame_ctrl
// Sequencing controller for a serial-in/parallel-out shift datapath.
// A start pulse clears the register and arms SHIFT; FRAME_BITS qualified
// bits are shifted in MSB-first, then the word is held on a valid/ready
// handshake. Bits arriving while the word waits are dropped and flagged.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : start_i, bit_valid_i, bit_i, word_ready_i in;
//                   word_valid_o, word_o out
//   busy_o        : high while in SHIFT
//   overrun_o     : sticky, a bit arrived during HOLD; cleared by accepted start
//   parity_err_o  : parity mismatch of the last frame (0 unless parity build)
// Build macro SHIFT_FRAME_CTRL_PARITY_EN: expect one even-parity beat after
// the data beats; it is checked, not stored, and the move to HOLD happens on it.
module shift_frame_ctrl
  import shift_frame_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FRAME_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  shift_frame_ctrl_if.slave   bus,
  output logic                busy_o,
  output logic                overrun_o,
  output logic                parity_err_o
);

`ifdef SHIFT_FRAME_CTRL_PARITY_EN
  localparam int BEATS = FRAME_BITS + 1;
`else
  localparam int BEATS = FRAME_BITS;
`endif
  localparam int CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] DATA_BEATS = CNT_W'(FRAME_BITS);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] sreg_d, sreg_q;
  logic             ovr_d, ovr_q;
  logic             cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0] cnt_q;
  logic             data_beat;
  logic             accept_start;

  frame_bit_counter #(
    .TERM  (BEATS),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt_q),
    .tc_o   (cnt_tc)
  );

  // Beats below FRAME_BITS carry data; with parity enabled the one after is the parity beat.
  assign data_beat = (cnt_q < DATA_BEATS);

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    ovr_d        = ovr_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    accept_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) accept_start = 1'b1;
      end
      S_SHIFT: begin
        // A restart beats a same-cycle bit; that bit is dropped.
        if (bus.start_i) begin
          accept_start = 1'b1;
        end else if (bus.bit_valid_i) begin
          cnt_inc = 1'b1;
          if (data_beat) sreg_d = {sreg_q[WIDTH-2:0], bus.bit_i};
          if (cnt_tc) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.bit_valid_i) ovr_d = 1'b1;
        // start is only honoured together with the handshake.
        if (bus.word_ready_i) begin
          state_d = S_IDLE;
          if (bus.start_i) accept_start = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept_start) begin
      state_d = S_SHIFT;
      sreg_d  = '0;
      ovr_d   = 1'b0;
      cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef SHIFT_FRAME_CTRL_PARITY_EN
  logic par_d, par_q;
  logic perr_d, perr_q;

  // Running XOR of the data bits, compared against the parity beat.
  always_comb begin
    par_d  = par_q;
    perr_d = perr_q;
    if (accept_start) begin
      par_d  = 1'b0;
      perr_d = 1'b0;
    end else if ((state_q == S_SHIFT) && bus.bit_valid_i) begin
      if (data_beat) par_d  = par_q ^ bus.bit_i;
      else           perr_d = par_q ^ bus.bit_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign busy_o           = (state_q == S_SHIFT);
  assign bus.word_valid_o = (state_q == S_HOLD);
  assign bus.word_o       = sreg_q;
  assign overrun_o        = ovr_q;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// tb_shift_frame_ctrl
// Directed bench for shift_frame_ctrl: one 8-bit-frame instance and one
// 4-bit-frame instance (WIDTH 8). Expected words are queued as frames are
// driven and popped when the controller raises word_valid_o.
// Honours SHIFT_FRAME_CTRL_PARITY_EN by appending parity beats.
module tb_shift_frame_ctrl;

`ifdef SHIFT_FRAME_CTRL_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_frame_ctrl_if #(.WIDTH(8)) bus8 ();
  shift_frame_ctrl_if #(.WIDTH(8)) bus4 ();

  logic busy8, ovr8, pe8;
  logic busy4, ovr4, pe4;

  shift_frame_ctrl #(.WIDTH(8), .FRAME_BITS(8)) u_dut8 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus          (bus8),
    .busy_o       (busy8),
    .overrun_o    (ovr8),
    .parity_err_o (pe8)
  );

  shift_frame_ctrl #(.WIDTH(8), .FRAME_BITS(4)) u_dut4 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus          (bus4),
    .busy_o       (busy4),
    .overrun_o    (ovr4),
    .parity_err_o (pe4)
  );

  typedef struct packed {
    logic [7:0] w;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic s, input logic v, input logic b);
    if (d == 0) begin
      bus8.start_i = s; bus8.bit_valid_i = v; bus8.bit_i = b;
    end else begin
      bus4.start_i = s; bus4.bit_valid_i = v; bus4.bit_i = b;
    end
  endtask

  task automatic beat(input int d, input logic b);
    drive(d, 1'b0, 1'b1, b);
    tick();
    drive(d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start(input int d);
    drive(d, 1'b1, 1'b0, 1'b0);
    tick();
    drive(d, 1'b0, 1'b0, 1'b0);
  endtask

  // Drives nbits data beats MSB-first (plus the parity beat when enabled,
  // inverted if flip) and queues the expected result.
  task automatic send_frame(input int d, input logic [7:0] w, input int nbits, input logic flip);
    exp_t e;
    e.w  = w;
    e.pe = PAR_EN ? flip : 1'b0;
    sb.push_back(e);
    for (int i = nbits - 1; i >= 0; i--) beat(d, w[i]);
    if (PAR_EN) beat(d, (^w) ^ flip);
  endtask

  function automatic logic get_valid(input int d);
    return (d == 0) ? bus8.word_valid_o : bus4.word_valid_o;
  endfunction

  function automatic logic [7:0] get_word(input int d);
    return (d == 0) ? bus8.word_o : bus4.word_o;
  endfunction

  function automatic logic get_pe(input int d);
    return (d == 0) ? pe8 : pe4;
  endfunction

  task automatic collect(input int d, input string tag);
    exp_t e;
    for (int i = 0; i < 20 && !get_valid(d); i++) tick();
    check({tag, "_valid"}, 32'(get_valid(d)), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_word"}, 32'(get_word(d)), 32'(e.w));
      check({tag, "_perr"}, 32'(get_pe(d)), 32'(e.pe));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    bus8.word_ready_i = 1'b0;
    bus4.word_ready_i = 1'b0;

    // Reset state
    #2;
    check("rst_busy",  32'(busy8), 32'd0);
    check("rst_valid", 32'(bus8.word_valid_o), 32'd0);
    check("rst_word",  32'(bus8.word_o), 32'd0);
    check("rst_ovr",   32'(ovr8), 32'd0);
    check("rst_perr",  32'(pe8), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic frame 8'ha5 with consumer ready
    bus8.word_ready_i = 1'b1;
    start(0);
    check("t1_busy", 32'(busy8), 32'd1);
    send_frame(0, 8'ha5, 8, 1'b0);
    check("t1_valid_lat", 32'(bus8.word_valid_o), 32'd1);
    collect(0, "t1");
    tick();
    check("t1_one_cycle", 32'(bus8.word_valid_o), 32'd0);
    check("t1_idle", 32'(busy8), 32'd0);

    // FRAME_BITS=4: second frame must not inherit bits of the first
    bus4.word_ready_i = 1'b1;
    start(1);
    send_frame(1, 8'h0f, 4, 1'b0);
    collect(1, "t2a");
    tick();
    start(1);
    send_frame(1, 8'h0d, 4, 1'b0);
    collect(1, "t2b");
    tick();
    check("t2_idle", 32'(bus4.word_valid_o), 32'd0);

    // Held word with overrun and ignored start
    bus8.word_ready_i = 1'b0;
    start(0);
    send_frame(0, 8'h5a, 8, 1'b0);
    collect(0, "t3");
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) drive(0, 1'b0, 1'b1, 1'b1);
      if (c == 4) drive(0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(0, 1'b0, 1'b0, 1'b0);
      check($sformatf("t3_hold_valid_%0d", c), 32'(bus8.word_valid_o), 32'd1);
      check($sformatf("t3_hold_word_%0d", c), 32'(bus8.word_o), 32'h5a);
      check($sformatf("t3_ovr_%0d", c), 32'(ovr8), (c >= 2) ? 32'd1 : 32'd0);
    end
    bus8.word_ready_i = 1'b1;
    tick();
    bus8.word_ready_i = 1'b0;
    check("t3_released", 32'(bus8.word_valid_o), 32'd0);
    check("t3_ovr_sticky", 32'(ovr8), 32'd1);
    start(0);
    check("t3_ovr_clr", 32'(ovr8), 32'd0);

    // Abort mid-frame; restart collides with a bit that must be dropped
    beat(0, 1'b1);
    beat(0, 1'b1);
    beat(0, 1'b1);
    drive(0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0);
    check("t4_busy", 32'(busy8), 32'd1);
    bus8.word_ready_i = 1'b1;
    send_frame(0, 8'h3c, 8, 1'b0);
    collect(0, "t4");
    tick();

    // Asynchronous reset during SHIFT
    start(0);
    for (int i = 0; i < 5; i++) beat(0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy8), 32'd0);
    check("t5_word", 32'(bus8.word_o), 32'd0);
    check("t5_valid", 32'(bus8.word_valid_o), 32'd0);
    check("t5_ovr", 32'(ovr8), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start(0);
    send_frame(0, 8'hc3, 8, 1'b0);
    collect(0, "t5_after");
    tick();

    // Asynchronous reset during HOLD
    bus8.word_ready_i = 1'b0;
    start(0);
    send_frame(0, 8'h81, 8, 1'b0);
    collect(0, "t6");
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid_drop", 32'(bus8.word_valid_o), 32'd0);
    check("t6_word", 32'(bus8.word_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef SHIFT_FRAME_CTRL_PARITY_EN
    // Bad parity beat
    bus8.word_ready_i = 1'b1;
    start(0);
    send_frame(0, 8'ha5, 8, 1'b1);
    collect(0, "t7");
    tick();
    check("t7_perr_sticky", 32'(pe8), 32'd1);
    start(0);
    check("t7_perr_clr", 32'(pe8), 32'd0);
    send_frame(0, 8'ha5, 8, 1'b0);
    collect(0, "t7_good");
    tick();
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_frame_ctrl.md
Name: shift_frame_ctrl

Overview:
- Sequencing controller for a serial-in/parallel-out shift datapath.
- Arms on a start pulse, clears the register, then shifts in exactly FRAME_BITS qualified serial bits MSB-first.
- Presents the captured word on a valid/ready output handshake.
- Sits between a bit-level line receiver and a word-level consumer; detects and flags bits dropped while a word is awaiting acceptance.

Parameters:
- WIDTH, 8, width of the parallel word and the internal shift register (>= 2).
- FRAME_BITS, 8, data bits per frame, 1..WIDTH; unused upper word bits read 0.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_ni  input  1  reset; asynchronous assert, active-low.
- start_i  input  1  begin (or restart) a frame.
- bit_valid_i  input  1  bit_i is valid this cycle.
- bit_i  input  1  serial data bit.
- busy_o  output  1  high in SHIFT state.
- word_valid_o  output  1  word_o holds a completed frame.
- word_ready_i  input  1  consumer accepts word_o when word_valid_o is high.
- word_o  output  WIDTH  captured frame; bit FRAME_BITS-1 is the first bit received.
- overrun_o  output  1  sticky: a bit_valid_i arrived while in HOLD.
- parity_err_o  output  1  parity mismatch flag (see Optional Feature).

Behaviour:
- Reset values (rst_ni low, asynchronous): state IDLE, bit count 0, shift register 0. All outputs 0: busy_o, word_valid_o, word_o, overrun_o, parity_err_o.
- States are IDLE, SHIFT and HOLD.
- IDLE:
  - bit_valid_i is ignored.
  - start_i -> shift register cleared, count <= 0, overrun_o <= 0, parity_err_o <= 0; next state SHIFT.
- SHIFT (busy_o=1):
  - bit_valid_i -> reg <= {reg[WIDTH-2:0], bit_i}; count++.
  - The beat that makes count reach FRAME_BITS -> next state HOLD; word_valid_o rises the following cycle (latency 1 clock from the final bit beat).
  - start_i in SHIFT -> frame aborted: reg cleared, count <= 0, remain in SHIFT. start_i has priority over a same-cycle bit_valid_i; that bit is discarded.
- HOLD (word_valid_o=1):
  - word_o is held stable until the handshake completes.
  - word_ready_i -> word consumed; next state IDLE, or SHIFT (with clear) if start_i is also high that cycle.
  - start_i without word_ready_i is ignored.
  - bit_valid_i in HOLD -> bit discarded, overrun_o <= 1. overrun_o stays set until the next accepted start.
- Count is $clog2(FRAME_BITS+1) bits wide and saturates at FRAME_BITS; no wrap.
- word_o equals the shift register directly. Bits above FRAME_BITS-1 are 0 because of the clear on start.
- Reset mid-frame or mid-HOLD forces IDLE immediately; the pending word is lost and word_valid_o drops asynchronously.

Optional Feature:
- Macro: SHIFT_FRAME_CTRL_PARITY_EN.
- Defined:
  - SHIFT expects one extra bit beat after the FRAME_BITS data beats. That bit is even parity over the data bits and is not shifted into the register.
  - The transition to HOLD occurs on the parity beat.
  - parity_err_o = 1 alongside word_valid_o when XOR(data bits, parity bit) = 1; it clears on the next accepted start.
  - Latency is one extra bit beat.
- Undefined: no parity beat; parity_err_o is tied to 0.

Decomposition:
- Package shift_frame_ctrl_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_HOLD=2'd2;
  - the count-width function.
- One sub-module, frame_bit_counter: clear, inc and saturating terminal-count output (terminal at FRAME_BITS, or FRAME_BITS+1 with parity).
- FSM and shift register stay in the top.

Test Plan:
- Reset, start, then 8 beats of bits 1,0,1,0,0,1,0,1 with word_ready_i=1 -> word_o=8'ha5 and word_valid_o high for 1 cycle, one clock after the 8th beat; back to IDLE.
- FRAME_BITS=4, WIDTH=8, bits 1,1,0,1 -> word_o=8'h0d, upper nibble 0.
- Frame complete with word_ready_i=0 for 5 cycles and bit_valid_i pulsed in cycle 2 -> word_o stable, overrun_o=1 until next start; after ready and start, overrun_o=0.
- Start, 3 bits, start again, then 8 bits of 8'h3c -> word_o=8'h3c; bits received before the second start are absent.
- rst_ni low while in SHIFT after 5 bits -> all outputs 0 without a clock edge; first frame after reset captures correctly.
- With SHIFT_FRAME_CTRL_PARITY_EN, data 8'ha5:
  - parity bit 0 -> parity_err_o=0;
  - parity bit 1 -> parity_err_o=1 with word_valid_o.
